sha256_msg_padder: RTL

//  Upstream stage of the SHA-256 compression core. Accepts a byte stream, packs bytes big-endian

---
 rtl/sha256_msg_padder_if.sv | 35 +++
 rtl/sha256_msg_padder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_padder_if.sv
// rtl/sha256_msg_padder_if.sv - byte-in / word-out handshake bundle for the SHA-256 message padder
//
// Purpose: groups the padder's byte input stream, padded word output stream and
// the sticky length-error flag so they can be passed as one port.
// Signals:
//   in_valid / in_ready / in_data[7:0] / in_last       byte stream into the padder
//   out_valid / out_ready / out_data[31:0]             padded word stream out of the padder
//   out_word_idx[3:0] / out_last                       word position in block, final-word marker
//   err_len                                            sticky byte-counter wrap flag
// Modports:
//   master - byte source / word consumer side
//   slave  - the padder itself

interface sha256_msg_padder_if;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [3:0]  out_word_idx;
   logic        out_last;
   logic        err_len;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_word_idx, out_last, err_len
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_word_idx, out_last, err_len
   );
endinterface

// File: rtl/sha256_msg_padder.sv
// rtl/sha256_msg_padder.sv - SHA-256 message padder: bytes in, padded 16-word blocks out
//
// Purpose: packs a byte stream big-endian into 32-bit words and appends the
// 0x80 marker, zero fill and 64-bit bit-length so the compression core sees
// complete 512-bit blocks. At most one word is in flight; the byte input is
// stalled while a word is offered.
// Ports:
//   clk      in  clock, all state on rising edge
//   reset_n  in  asynchronous active-low reset
//   bus      sha256_msg_padder_if.slave: in_valid/in_ready/in_data/in_last byte
//            stream, out_valid/out_ready/out_data/out_word_idx/out_last word
//            stream, err_len sticky counter-wrap flag

module sha256_msg_padder #(
   parameter int CNT_W = 32
) (
   input logic                   clk,
   input logic                   reset_n,
   sha256_msg_padder_if.slave    bus
);

   typedef enum logic [2:0] {
      S_DATA  = 3'd0,
      S_EMIT  = 3'd1,
      S_PAD   = 3'd2,
      S_ZERO  = 3'd3,
      S_LENHI = 3'd4,
      S_LENLO = 3'd5
   } state_t;

   state_t             state_q, state_d;
   logic [31:0]        buf_q, buf_d;
   logic [1:0]         pos_q, pos_d;        // bytes already held in buf_q for the current word
   logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
   logic [3:0]         idx_q, idx_d;
   logic               out_valid_q, out_valid_d;
   logic [31:0]        out_data_q, out_data_d;
   logic               out_last_q, out_last_d;
   logic               err_len_q, err_len_d;
   logic               in_ready_q, in_ready_d;
   logic               pad_full_q, pad_full_d; // last data word was full: 0x80000000 still owed

   logic               in_acc;
   logic               out_acc;
   logic [31:0]        new_buf;
   logic [63:0]        len_bits;

   assign in_acc   = bus.in_valid & in_ready_q;
   assign out_acc  = out_valid_q & bus.out_ready;
   assign new_buf  = {buf_q[23:0], bus.in_data};
   assign len_bits = {{(61 - CNT_W){1'b0}}, byte_cnt_q, 3'b000};

   always_comb begin
      state_d     = state_q;
      buf_d       = buf_q;
      pos_d       = pos_q;
      byte_cnt_d  = byte_cnt_q;
      idx_d       = idx_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      err_len_d   = err_len_q;
      in_ready_d  = in_ready_q;
      pad_full_d  = pad_full_q;

      case (state_q)
         S_DATA: begin
            // Raises in_ready on the first clock after reset as well.
            in_ready_d = 1'b1;
            if (in_acc) begin
               buf_d      = new_buf;
               pos_d      = pos_q + 2'd1;
               byte_cnt_d = byte_cnt_q + CNT_W'(1);
               if (&byte_cnt_q) begin
                  err_len_d = 1'b1;
               end
               if (bus.in_last) begin
                  pos_d       = 2'd0;
                  out_valid_d = 1'b1;
                  in_ready_d  = 1'b0;
                  state_d     = S_PAD;
                  // 0x80 goes in the byte lane just after the final message byte.
                  case (pos_q)
                     2'd0:    out_data_d = {bus.in_data, 8'h80, 16'h0000};
                     2'd1:    out_data_d = {buf_q[7:0], bus.in_data, 8'h80, 8'h00};
                     2'd2:    out_data_d = {buf_q[15:0], bus.in_data, 8'h80};
                     default: begin
                        out_data_d = new_buf;
                        pad_full_d = 1'b1;
                     end
                  endcase
               end else if (pos_q == 2'd3) begin
                  pos_d       = 2'd0;
                  out_valid_d = 1'b1;
                  in_ready_d  = 1'b0;
                  out_data_d  = new_buf;
                  state_d     = S_EMIT;
               end
            end
         end

         S_EMIT: begin
            if (out_acc) begin
               idx_d       = idx_q + 4'd1;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = S_DATA;
            end
         end

         S_PAD: begin
            if (out_acc) begin
               idx_d = idx_q + 4'd1;
               if (pad_full_q) begin
                  pad_full_d = 1'b0;
                  out_data_d = 32'h8000_0000;
               end else if (idx_q == 4'd13) begin
                  // Marker word sat at idx 13: length fits in this block.
                  out_data_d = len_bits[63:32];
                  state_d    = S_LENHI;
               end else begin
                  out_data_d = 32'h0;
                  state_d    = S_ZERO;
               end
            end
         end

         S_ZERO: begin
            // Zero fill runs through idx 15 -> 0 into a fresh block if needed.
            if (out_acc) begin
               idx_d = idx_q + 4'd1;
               if (idx_q == 4'd13) begin
                  out_data_d = len_bits[63:32];
                  state_d    = S_LENHI;
               end
            end
         end

         S_LENHI: begin
            if (out_acc) begin
               idx_d      = idx_q + 4'd1;
               out_data_d = len_bits[31:0];
               out_last_d = 1'b1;
               state_d    = S_LENLO;
            end
         end

         S_LENLO: begin
            if (out_acc) begin
               idx_d       = 4'd0;
               byte_cnt_d  = '0;
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = S_DATA;
            end
         end

         default: begin
            state_d     = S_DATA;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_DATA;
         buf_q       <= 32'h0;
         pos_q       <= 2'd0;
         byte_cnt_q  <= '0;
         idx_q       <= 4'd0;
         out_valid_q <= 1'b0;
         out_data_q  <= 32'h0;
         out_last_q  <= 1'b0;
         err_len_q   <= 1'b0;
         in_ready_q  <= 1'b0;
         pad_full_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         buf_q       <= buf_d;
         pos_q       <= pos_d;
         byte_cnt_q  <= byte_cnt_d;
         idx_q       <= idx_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         err_len_q   <= err_len_d;
         in_ready_q  <= in_ready_d;
         pad_full_q  <= pad_full_d;
      end
   end

   assign bus.in_ready     = in_ready_q;
   assign bus.out_valid    = out_valid_q;
   assign bus.out_data     = out_data_q;
   assign bus.out_word_idx = idx_q;
   assign bus.out_last     = out_last_q;
   assign bus.err_len      = err_len_q;

endmodule
